// File: rtl/ysyx_22041207_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes and FSM states.
// No logic; latency and backpressure are properties of the top module.
// Operand signedness helpers live here so every user decodes funct3 the same way.
package ysyx_22041207_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // MUL only keeps the low half, so treating it as signed is harmless.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_22041207_mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the step is committed.
module ysyx_22041207_mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] diff;

    // The bit shifted out of rem_in is the implicit MSB of an XLEN+1 bit partial remainder.
    assign shifted = {rem_in[XLEN-2:0], bit_in};
    assign diff    = shifted - divisor;
    assign q_bit   = rem_in[XLEN-1] | (shifted >= divisor);
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/ysyx_22041207_mdu.sv
// Iterative RV64M/RV32M multiply/divide unit; YSYX_22041207_MDU_FAST_MUL_EN selects a one-cycle multiplier.
// Latency: out_valid rises N+2 cycles after acceptance (N = XLEN, or 32 for W ops); div-by-zero/overflow take 2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module ysyx_22041207_mdu
    import ysyx_22041207_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    mdu_state_e        state;
    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;
    logic              special_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] prod_q;

    logic            word_eff, a_sgn, b_sgn, a_neg, b_neg, is_div, is_rem;
    logic            div_zero, div_ovf, special, neg;
    logic [XLEN-1:0] a_x, b_x, a_mag, b_mag, min_x, sp_val;
    logic [CW-1:0]   cnt_init;

    assign in_ready = (state == IDLE);

    always_comb begin
        word_eff = in_word && (XLEN == 64);
        a_sgn    = op_a_signed(in_op);
        b_sgn    = op_b_signed(in_op);
        a_x      = in_a;
        b_x      = in_b;
        min_x    = '0;
        min_x[XLEN-1] = 1'b1;
        if (word_eff) begin
            a_x   = a_sgn ? sext32(in_a[31:0]) : XLEN'(in_a[31:0]);
            b_x   = b_sgn ? sext32(in_b[31:0]) : XLEN'(in_b[31:0]);
            min_x = sext32(32'h8000_0000);
        end
        a_neg    = a_sgn & a_x[XLEN-1];
        b_neg    = b_sgn & b_x[XLEN-1];
        a_mag    = a_neg ? -a_x : a_x;
        b_mag    = b_neg ? -b_x : b_x;
        is_div   = in_op[2];
        is_rem   = in_op[1];
        div_zero = is_div && (b_x == '0);
        div_ovf  = is_div && a_sgn && (a_x == min_x) && (b_x == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            sp_val = is_rem ? a_x : '1;
        else
            sp_val = is_rem ? '0 : a_x;
        // Remainder takes the dividend's sign; quotient and product take the XOR.
        neg      = (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
        cnt_init = word_eff ? CW'(31) : CW'(XLEN-1);
`ifdef YSYX_22041207_MDU_FAST_MUL_EN
        if (!is_div)
            cnt_init = '0;
`endif
    end

    logic [XLEN-1:0] div_rem;
    logic            div_q;

    ysyx_22041207_mdu_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (prod_q[2*XLEN-1:XLEN]),
        .bit_in  (prod_q[XLEN-1]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

`ifndef YSYX_22041207_MDU_FAST_MUL_EN
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
`endif

    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        mul_prod = prod_q;
`ifndef YSYX_22041207_MDU_FAST_MUL_EN
        // A 32-step shift-add leaves the word product XLEN-32 bits above its natural place.
        if (word_q)
            mul_prod = prod_q >> (XLEN - 32);
`endif
        if (neg_q)
            mul_prod = -mul_prod;
        div_val = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (special_q)
            fix_res = prod_q[XLEN-1:0];
        else if (!op_q[2])
            fix_res = (op_q == MDU_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        else
            fix_res = neg_q ? -div_val : div_val;
        if (word_q)
            fix_res = sext32(fix_res[31:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            cnt       <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            out_res   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q      <= in_op;
                    word_q    <= word_eff;
                    cnt       <= cnt_init;
                    special_q <= special;
                    busy      <= 1'b1;
                    if (special) begin
                        neg_q  <= 1'b0;
                        prod_q <= {{XLEN{1'b0}}, sp_val};
                        state  <= FIX;
                    end else begin
                        neg_q <= neg;
                        state <= BUSY;
                        if (is_div) begin
                            opnd_q <= b_mag;
                            prod_q <= {{XLEN{1'b0}}, word_eff ? (a_mag << (XLEN - 32)) : a_mag};
                        end else begin
                            opnd_q <= a_mag;
`ifdef YSYX_22041207_MDU_FAST_MUL_EN
                            prod_q <= {a_mag, b_mag};
`else
                            prod_q <= {{XLEN{1'b0}}, b_mag};
`endif
                        end
                    end
                end
                BUSY: begin
                    if (op_q[2])
                        prod_q <= {div_rem, prod_q[XLEN-2:0], div_q};
                    else
`ifdef YSYX_22041207_MDU_FAST_MUL_EN
                        prod_q <= (2*XLEN)'(prod_q[2*XLEN-1:XLEN]) * (2*XLEN)'(prod_q[XLEN-1:0]);
`else
                        prod_q <= {mul_sum, prod_q[XLEN-1:1]};
`endif
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    out_res   <= fix_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_mdu.sv
// Directed-vector bench for ysyx_22041207_mdu (XLEN=64): results, latency, flush and DONE hold.
module tb_ysyx_22041207_mdu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_word, out_valid, out_ready, busy;
    logic [2:0]  in_op;
    logic [63:0] in_a, in_b, out_res;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22041207_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_word   (in_word),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure cycles to out_valid, optionally stall the consumer, then retire it.
    task automatic do_op(input string tag, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
        int lat;
        int bad;
        logic [63:0] r;
        @(negedge clk);
        in_op = op; in_word = w; in_a = a; in_b = b; in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            in_a = ~a;
            in_b = ~b;
            in_op = ~op;
            in_word = ~w;
        end while (!out_valid && lat < 300);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        r = out_res;
        check({tag, " result"}, r, exp_res);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_res !== r || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
                bad++;
        end
        if (hold > 0)
            check({tag, " hold"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " retire"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    initial begin
        int bad;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_word = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready",  {63'd0, in_ready},  64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy",      {63'd0, busy},      64'd0);
        check("reset out_res",   out_res,            64'd0);

        do_op("MUL 3*-5",     3'd0, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 66, 0);
        do_op("MULH pos",     3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 66, 0);
        do_op("MULH neg",     3'd1, 1'b0, 64'hC000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        do_op("MULHU max",    3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        do_op("MULHSU -1*2",  3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        do_op("DIV -7/2",     3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
        do_op("REM -7%2",     3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        do_op("REMU 100%7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
        do_op("DIVU 7/0",     3'd5, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        do_op("REMU 7%0",     3'd7, 1'b0, 64'd7, 64'd0, 64'd7, 2, 0);
        do_op("DIV ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 0);
        do_op("REM ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
        do_op("DIVW ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2, 0);
        do_op("MULW",         3'd0, 1'b1, 64'h5555_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        do_op("DIVUW",        3'd5, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 0);
        do_op("REMW -7%2",    3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);

        // Flush asserted together with in_valid must block acceptance.
        @(negedge clk);
        in_op = 3'd4; in_word = 1'b0; in_a = 64'd50; in_b = 64'd5; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", {62'd0, in_ready, busy}, 64'b10);

        // Flush ten cycles into a DIV.
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("div in flight", {62'd0, in_ready, busy}, 64'b01);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", {62'd0, in_ready, busy}, 64'b10);
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("flush no out_valid", 64'(bad), 64'd0);

        do_op("MUL 6*7 hold", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 66, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
